// File: rtl/spi_master_mode.sv
// spi_master_mode: full-duplex SPI master, all CPOL/CPHA modes,
// programmable sclk divider and decoded active-low chip selects.
module spi_master_mode #(
  parameter int N        = 16,
  parameter int DIV      = 4,
  parameter int CS_SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N-1:0]           in_data,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic [CS_SEL_W-1:0]    cs_sel,
  input  logic                   miso,
  output logic                   sclk,
  output logic [2**CS_SEL_W-1:0] cs,
  output logic                   mosi,
  output logic                   busy,
  output logic                   done,
  output logic [N-1:0]           out_data
);

  localparam int NUM_CS = 2**CS_SEL_W;
  localparam int CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW     = $clog2(2*N+1);

  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV-1);
  localparam logic [BW-1:0] EDGE_LAST = BW'(2*N-1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       ecnt;
  logic [N-1:0]        tx;
  logic [N-1:0]        rx;
  logic                cpol_q;
  logic                cpha_q;
  logic [CS_SEL_W-1:0] sel_q;

  logic half_end;
  logic shift_edge;
  logic last_edge;

  // ecnt holds edges already made; even count means next is leading.
  // With CPHA=0 the shift edges are trailing, with CPHA=1 leading.
  assign half_end   = (cnt == CNT_MAX);
  assign shift_edge = ecnt[0] ^ cpha_q;
  assign last_edge  = (ecnt == EDGE_LAST);

  // Frame sequencer: IDLE -> SETUP -> XFER -> HOLD, all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ecnt     <= '0;
      tx       <= '0;
      rx       <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sel_q    <= '0;
      sclk     <= 1'b0;
      cs       <= '1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_data <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          sclk <= cpol_q;
          cs   <= '1;
          busy <= 1'b0;
          if (start) begin
            state  <= SETUP;
            busy   <= 1'b1;
            cpol_q <= cpol;
            cpha_q <= cpha;
            sel_q  <= cs_sel;
            cnt    <= '0;
            ecnt   <= '0;
            sclk   <= cpol;
            cs     <= ~(NUM_CS'(1) << cs_sel);
            if (cpha) begin
              tx <= in_data;
            end else begin
              mosi <= in_data[N-1];
              tx   <= {in_data[N-2:0], 1'b0};
            end
          end
        end
        SETUP: begin
          cs  <= ~(NUM_CS'(1) << sel_q);
          cnt <= half_end ? '0 : cnt + 1'b1;
          if (half_end) state <= XFER;
        end
        XFER: begin
          cnt <= half_end ? '0 : cnt + 1'b1;
          if (half_end) begin
            sclk <= ~sclk;
            ecnt <= ecnt + 1'b1;
            if (!shift_edge) begin
              rx <= {rx[N-2:0], miso};
            end else if (!last_edge) begin
              mosi <= tx[N-1];
              tx   <= {tx[N-2:0], 1'b0};
            end
            if (last_edge) state <= HOLD;
          end
        end
        HOLD: begin
          cnt <= half_end ? '0 : cnt + 1'b1;
          if (half_end) begin
            state    <= IDLE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cs       <= '1;
            out_data <= rx;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_mode.sv
// tb_spi_master_mode: directed vectors for spi_master_mode,
// two instances (DIV=2 and DIV=3) sharing one slave model.
module tb_spi_master_mode;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] in_data;
  logic       cpol;
  logic       cpha;
  logic [1:0] cs_sel;
  logic       miso;
  logic       use_b;
  logic       start_a;
  logic       start_b;

  logic       sclk_a, mosi_a, busy_a, done_a;
  logic [3:0] cs_a;
  logic [7:0] out_a;
  logic       sclk_b, mosi_b, busy_b, done_b;
  logic [3:0] cs_b;
  logic [7:0] out_b;

  logic       sclk, mosi, busy, done;
  logic [3:0] cs;
  logic [7:0] out_data;

  int pass_cnt = 0;
  int total    = 0;

  assign start_a  = start & ~use_b;
  assign start_b  = start & use_b;
  assign sclk     = use_b ? sclk_b : sclk_a;
  assign mosi     = use_b ? mosi_b : mosi_a;
  assign busy     = use_b ? busy_b : busy_a;
  assign done     = use_b ? done_b : done_a;
  assign cs       = use_b ? cs_b   : cs_a;
  assign out_data = use_b ? out_b  : out_a;

  spi_master_mode #(.N(8), .DIV(2), .CS_SEL_W(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_data(in_data),
    .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel), .miso(miso),
    .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .busy(busy_a),
    .done(done_a), .out_data(out_a)
  );

  spi_master_mode #(.N(8), .DIV(3), .CS_SEL_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_data(in_data),
    .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel), .miso(miso),
    .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .busy(busy_b),
    .done(done_b), .out_data(out_b)
  );

  always #5 clk = ~clk;

  // slave model: shifts out on the master's shift edge, samples on the other
  logic       loopback = 1'b1;
  logic       s_cpol = 1'b0;
  logic       s_cpha = 1'b0;
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic       s_miso = 1'b0;
  logic       act;
  logic       act_q = 1'b0;
  logic       sclk_q = 1'b0;

  assign act  = (cs != 4'hF);
  assign miso = loopback ? mosi : s_miso;

  always @(negedge clk) begin
    if (act && !act_q) begin
      if (!s_cpha) begin
        s_miso = s_tx[7];
        s_tx   = {s_tx[6:0], 1'b0};
      end
    end else if (act && (sclk != sclk_q)) begin
      if ((sclk != s_cpol) == s_cpha) begin
        s_miso = s_tx[7];
        s_tx   = {s_tx[6:0], 1'b0};
      end else begin
        s_rx = {s_rx[6:0], mosi};
      end
    end
    act_q  = act;
    sclk_q = sclk;
  end

  task automatic chk(input string name, input logic [31:0] act_v,
                     input logic [31:0] exp_v);
    total++;
    if (act_v === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
  endtask

  typedef struct {
    logic       use_b;
    logic       cpol;
    logic       cpha;
    logic [1:0] sel;
    logic [7:0] din;
    logic [7:0] sdata;
    logic       lb;
    logic       poke;
    logic [7:0] exp_out;
    int         exp_low;
    int         exp_done;
  } vec_t;

  task automatic run_frame(input vec_t v, input string tag);
    int         rises;
    int         lowc;
    int         done_at;
    logic       others_ok;
    logic       prev;
    logic [3:0] mask;
    @(negedge clk);
    use_b    = v.use_b;
    loopback = v.lb;
    s_cpol   = v.cpol;
    s_cpha   = v.cpha;
    s_tx     = v.sdata;
    s_rx     = 8'h00;
    cpol     = v.cpol;
    cpha     = v.cpha;
    cs_sel   = v.sel;
    in_data  = v.din;
    start    = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    mask      = 4'd1 << v.sel;
    rises     = 0;
    lowc      = 0;
    done_at   = 0;
    others_ok = 1'b1;
    prev      = sclk;
    chk($sformatf("%s_sclk_first", tag), sclk, v.cpol);
    for (int c = 1; c <= 200; c++) begin
      if (v.poke && c == 10) begin
        start   = 1'b1;
        in_data = ~v.din;
        cpol    = ~v.cpol;
        cpha    = ~v.cpha;
        cs_sel  = v.sel + 2'd1;
      end else if (v.poke && c == 11) begin
        start = 1'b0;
      end
      if ((cs & mask) == 4'h0) lowc++;
      if ((cs | mask) != 4'hF) others_ok = 1'b0;
      if (sclk && !prev) rises++;
      prev = sclk;
      if (done) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("%s_done_at", tag), done_at, v.exp_done);
    chk($sformatf("%s_cs_low", tag), lowc, v.exp_low);
    chk($sformatf("%s_cs_others", tag), others_ok, 1'b1);
    chk($sformatf("%s_rises", tag), rises, 8);
    chk($sformatf("%s_out", tag), out_data, v.exp_out);
    chk($sformatf("%s_slave_rx", tag), s_rx, v.din);
    chk($sformatf("%s_busy_done", tag), busy, 1'b0);
    chk($sformatf("%s_cs_done", tag), cs, 4'hF);
    @(negedge clk);
    chk($sformatf("%s_done_1cyc", tag), done, 1'b0);
    chk($sformatf("%s_sclk_idle", tag), sclk, v.cpol);
  endtask

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dones;
    int   edges;
    int   c;
    logic prev;
    logic done_seen;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b1, 1'b0, 8'hA5, 36, 37};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h0F, 8'h3C, 1'b0, 1'b0, 8'h3C, 54, 55};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h96, 8'h3C, 1'b0, 1'b0, 8'h3C, 54, 55};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd3, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h3C, 54, 55};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 2'd2, 8'h7E, 8'h81, 1'b0, 1'b0, 8'h81, 36, 37};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h39, 8'hC6, 1'b0, 1'b1, 8'hC6, 36, 37};

    reset   = 1'b1;
    start   = 1'b0;
    in_data = 8'h00;
    cpol    = 1'b0;
    cpha    = 1'b0;
    cs_sel  = 2'd0;
    use_b   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_cs", cs, 4'hF);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", out_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    // back-to-back: start held high through done
    @(negedge clk);
    use_b    = 1'b0;
    loopback = 1'b1;
    cpol     = 1'b0;
    cpha     = 1'b0;
    cs_sel   = 2'd0;
    in_data  = 8'h5A;
    start    = 1'b1;
    @(negedge clk);
    in_data   = 8'hC3;
    dones     = 0;
    c         = 1;
    done_seen = 1'b0;
    while (c <= 200 && !done_seen) begin
      if (done) begin
        dones++;
        if (dones == 1) begin
          chk("b2b_done1_at", c, 37);
          chk("b2b_out1", out_data, 8'h5A);
          chk("b2b_cs_gap", cs, 4'hF);
          @(negedge clk);
          c++;
          start = 1'b0;
          chk("b2b_cs_low", cs, 4'hE);
          chk("b2b_busy2", busy, 1'b1);
        end else begin
          chk("b2b_done2_at", c, 74);
          chk("b2b_out2", out_data, 8'hC3);
          done_seen = 1'b1;
        end
      end
      if (!done_seen) begin
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    chk("b2b_dones", dones, 2);
    @(negedge clk);

    // reset at the 5th sclk edge of a frame
    @(negedge clk);
    cs_sel  = 2'd1;
    in_data = 8'h33;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    prev  = sclk;
    for (int k = 0; k < 200 && edges < 5; k++) begin
      @(negedge clk);
      if (sclk != prev) edges++;
      prev = sclk;
    end
    chk("mrst_edges", edges, 5);
    reset = 1'b1;
    #1;
    chk("mrst_cs", cs, 4'hF);
    chk("mrst_sclk", sclk, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_out", out_data, 8'h00);
    chk("mrst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mrst_no_done", dones, 0);
    run_frame('{1'b0, 1'b0, 1'b0, 2'd1, 8'hE7, 8'h00, 1'b1, 1'b0, 8'hE7,
                36, 37}, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
